// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM encoding
//   arb_owner_e : which requester holds the current grant
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_IF_WAIT = 2'b01,
    ARB_D_WAIT  = 2'b10,
    ARB_RESP    = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  function automatic logic arb_is_wait(arb_state_e s);
    return (s == ARB_IF_WAIT) || (s == ARB_D_WAIT);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-ack watchdog: counts wait cycles without an ack and raises a sticky
// error once the count reaches TIMEOUT. TIMEOUT=0 disables the check.
//   clk, rst : clock, async active-high reset
//   waiting  : a memory access is outstanding this cycle
//   ack      : memory completed the access this cycle
//   clear    : arbiter idle, restart the count
//   err      : sticky timeout flag (cleared only by reset)
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  input  logic clear,
  output logic err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear || ack)
      cnt_d = '0;
    else if (waiting && (cnt_q != LIMIT))  // saturate at LIMIT
      cnt_d = cnt_q + 1'b1;
    // Flag on the edge where the count reaches the limit; the FSM keeps waiting.
    if ((TIMEOUT != 0) && waiting && !ack && (cnt_d == LIMIT))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and
// M-stage load/store. Data has priority; one access at a time via a
// request/ack handshake; each completion is signalled by a one-cycle valid.
//   clk, reset                      : clock, async active-high reset
//   if_req/if_addr/if_kill          : fetch request, PC, redirect kill
//   if_rdata/if_valid               : fetched instruction, completion pulse
//   d_req/d_we/d_addr/d_wdata       : load/store request
//   d_rdata/d_valid                 : load data, completion pulse
//   mem_req/we/addr/wdata           : registered memory request (held until ack)
//   mem_rdata/mem_ack               : memory response
//   stall_fetch/stall_mem           : stall terms for the hazard unit
//   timeout_err                     : sticky ack timeout flag
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            stall_fetch,
  output logic            stall_mem,
  output logic            timeout_err
);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic            kill_q, kill_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        kill_d = 1'b0;
        if (d_req) begin
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          owner_d     = OWN_D;
          state_d     = ARB_D_WAIT;
        end else if (if_req && !if_kill) begin
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          owner_d    = OWN_IF;
          state_d    = ARB_IF_WAIT;
        end
      end
      ARB_IF_WAIT: begin
        // A killed fetch still completes on the bus; only its response is dropped.
        if (if_kill) kill_d = 1'b1;
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          state_d    = ARB_RESP;
        end
      end
      ARB_D_WAIT: begin
        if (mem_ack) begin
          if (!mem_we_q) d_rdata_d = mem_rdata;  // stores leave d_rdata alone
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        // Never re-grant here: the requester is still high while the pipe advances.
        kill_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      kill_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Request decoded straight from state so an async reset drops it at once.
  assign mem_req   = arb_is_wait(state_q);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // A kill arriving in RESP itself must also squash the pulse.
  assign if_valid = (state_q == ARB_RESP) && (owner_q == OWN_IF) && !kill_q && !if_kill;
  assign d_valid  = (state_q == ARB_RESP) && (owner_q == OWN_D);

  assign stall_fetch = if_req & ~if_valid;
  assign stall_mem   = d_req & ~d_valid;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (reset),
    .waiting (mem_req),
    .ack     (mem_ack),
    .clear   (state_q == ARB_IDLE),
    .err     (timeout_err)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req, if_kill, d_req, d_we, mem_ack;
  logic [XLEN-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [XLEN-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic            if_valid, d_valid, mem_req, mem_we;
  logic            stall_fetch, stall_mem, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; bit chk_wd; } req_t;
  typedef struct { bit is_d; logic [31:0] data; } rsp_t;
  typedef struct { int delay; logic [31:0] rdata; } mrsp_t;  // delay<0: never ack

  req_t  exp_req[$];
  rsp_t  exp_rsp[$];
  mrsp_t mem_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int   wcnt;
    bit   active;
    mrsp_t cur;
    wcnt = 0; active = 0; cur.delay = -1; cur.rdata = '0;
    mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!active) begin
          active = 1; wcnt = 0;
          if (mem_q.size() > 0) cur = mem_q.pop_front();
          else begin cur.delay = -1; cur.rdata = '0; end
        end
        if (cur.delay >= 0 && wcnt == cur.delay) begin
          mem_ack = 1'b1; mem_rdata = cur.rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
        end
        wcnt++;
      end else begin
        active = 0; mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // ---------------- request monitor ----------------
  initial begin
    logic        prev_req;
    logic        h_we;
    logic [31:0] h_addr, h_wd;
    req_t        e;
    prev_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_req.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_grant: got addr 0x%08h we %b required no grant", mem_addr, mem_we);
        end else begin
          e = exp_req.pop_front();
          chkb("req_we", mem_we, e.we);
          chk("req_addr", mem_addr, e.addr);
          if (e.chk_wd) chk("req_wdata", mem_wdata, e.wdata);
        end
        h_we = mem_we; h_addr = mem_addr; h_wd = mem_wdata;
      end else if (mem_req) begin
        chk("addr_stable", mem_addr, h_addr);
        chk("wdata_stable", mem_wdata, h_wd);
        chkb("we_stable", mem_we, h_we);
      end
      prev_req = mem_req;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!reset && (if_valid || d_valid)) begin
        chkb("valid_onehot", if_valid & d_valid, 1'b0);
        if (exp_rsp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got if_valid %b d_valid %b required none", if_valid, d_valid);
        end else begin
          r = exp_rsp.pop_front();
          chkb("rsp_kind_d", d_valid, r.is_d);
          chk("rsp_data", d_valid ? d_rdata : if_rdata, r.data);
          chkb("rsp_stall", d_valid ? stall_mem : stall_fetch, 1'b0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold requests until their valid pulse, then drop them like the pipeline would.
  task automatic serve(input int budget, output int lat_if, output int lat_d);
    int   cyc;
    logic dv, iv;
    cyc = 0; lat_if = -1; lat_d = -1;
    while ((if_req || d_req) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      dv = d_valid; iv = if_valid;
      if (dv && lat_d < 0) lat_d = cyc;
      if (iv && lat_if < 0) lat_if = cyc;
      @(posedge clk); #1;
      if (dv) d_req = 1'b0;
      if (iv) if_req = 1'b0;
    end
    if (if_req || d_req) begin
      n_tests++; n_fail++;
      $display("FAIL serve_timeout: requests still pending (if %b d %b) after %0d cycles", if_req, d_req, budget);
      if_req = 1'b0; d_req = 1'b0;
    end
  endtask

  function automatic req_t mk_req(logic we, logic [31:0] a, logic [31:0] wd, bit cw);
    req_t q; q.we = we; q.addr = a; q.wdata = wd; q.chk_wd = cw; return q;
  endfunction
  function automatic rsp_t mk_rsp(bit is_d, logic [31:0] d);
    rsp_t q; q.is_d = is_d; q.data = d; return q;
  endfunction
  function automatic mrsp_t mk_mem(int dl, logic [31:0] d);
    mrsp_t q; q.delay = dl; q.rdata = d; return q;
  endfunction

  initial begin
    int li, ld;
    reset = 1'b1; if_req = 0; if_kill = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_if_valid", if_valid, 1'b0);
    chkb("rst_d_valid", d_valid, 1'b0);
    chkb("rst_timeout", timeout_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // T1: fetch, ack in first wait cycle
    exp_req.push_back(mk_req(1'b0, 32'h100, 32'h0, 0));
    exp_rsp.push_back(mk_rsp(0, 32'h00500093));
    mem_q.push_back(mk_mem(0, 32'h00500093));
    if_addr = 32'h100; if_req = 1'b1;
    serve(20, li, ld);
    chk("t1_latency", 32'(li), 32'd3);
    tick();

    // T2: simultaneous store and fetch; store first, fetch after
    exp_req.push_back(mk_req(1'b1, 32'h2000, 32'hDEADBEEF, 1));
    exp_req.push_back(mk_req(1'b0, 32'h300, 32'h0, 0));
    exp_rsp.push_back(mk_rsp(1, 32'h0));           // store: d_rdata keeps its old value
    exp_rsp.push_back(mk_rsp(0, 32'h00A00113));
    mem_q.push_back(mk_mem(0, 32'hAAAAAAAA));
    mem_q.push_back(mk_mem(0, 32'h00A00113));
    d_addr = 32'h2000; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    @(negedge clk);
    chkb("t2_stall_mem", stall_mem, 1'b1);
    chkb("t2_stall_fetch", stall_fetch, 1'b1);
    serve(30, li, ld);
    chk("t2_d_before_if", 32'(ld < li), 32'd1);
    d_we = 1'b0;
    tick();

    // T3: fetch killed in its 2nd wait cycle, slow ack; redirected fetch follows
    exp_req.push_back(mk_req(1'b0, 32'h400, 32'h0, 0));
    exp_req.push_back(mk_req(1'b0, 32'h500, 32'h0, 0));
    exp_rsp.push_back(mk_rsp(0, 32'h22222222));
    mem_q.push_back(mk_mem(4, 32'h11111111));
    mem_q.push_back(mk_mem(0, 32'h22222222));
    if_addr = 32'h400; if_req = 1'b1;
    tick();               // granted: now in 1st wait cycle
    tick();               // 2nd wait cycle
    if_kill = 1'b1; if_addr = 32'h500;
    #2 chkb("t3_kill_no_valid", if_valid, 1'b0);
    tick();
    if_kill = 1'b0;
    serve(30, li, ld);
    chk("t3_if_rdata", if_rdata, 32'h22222222);
    tick();

    // T4: load, ack after 2 cycles; no second grant afterwards
    exp_req.push_back(mk_req(1'b0, 32'h40, 32'h0, 0));
    exp_rsp.push_back(mk_rsp(1, 32'h12345678));
    mem_q.push_back(mk_mem(2, 32'h12345678));
    d_addr = 32'h40; d_we = 1'b0; d_wdata = 32'h0; d_req = 1'b1;
    serve(20, li, ld);
    chk("t4_latency", 32'(ld), 32'd5);
    repeat (4) tick();
    chk("t4_d_rdata_held", d_rdata, 32'h12345678);

    // T5: timeout after 8 wait cycles, late ack still completes
    exp_req.push_back(mk_req(1'b0, 32'h80, 32'h0, 0));
    exp_rsp.push_back(mk_rsp(1, 32'hCAFEF00D));
    mem_q.push_back(mk_mem(12, 32'hCAFEF00D));
    d_addr = 32'h80; d_req = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chkb("t5_err_not_yet", timeout_err, 1'b0);
    @(negedge clk);
    chkb("t5_err_set", timeout_err, 1'b1);
    @(posedge clk); #1;
    serve(30, li, ld);
    repeat (2) tick();
    chkb("t5_err_sticky", timeout_err, 1'b1);
    reset = 1'b1; #2;
    chkb("t5_err_reset", timeout_err, 1'b0);
    tick(); reset = 1'b0; tick();

    // T6: async reset in the middle of a data wait
    exp_req.push_back(mk_req(1'b0, 32'h44, 32'h0, 0));
    mem_q.push_back(mk_mem(-1, 32'h0));
    d_addr = 32'h44; d_req = 1'b1;
    tick();
    @(negedge clk);
    chkb("t6_req_before", mem_req, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chkb("t6_mem_req", mem_req, 1'b0);
    chkb("t6_d_valid", d_valid, 1'b0);
    chkb("t6_if_valid", if_valid, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    d_req = 1'b0;
    tick(); reset = 1'b0;
    repeat (3) tick();

    chk("req_q_empty", 32'(exp_req.size()), 32'd0);
    chk("rsp_q_empty", 32'(exp_rsp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
